// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets and default parameters shared by the GPIO controller
package gpio_pkg;
    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam logic [2:0] GPIO_MODER   = 3'd0;
    localparam logic [2:0] GPIO_IDR     = 3'd1;
    localparam logic [2:0] GPIO_ODR     = 3'd2;
    localparam logic [2:0] GPIO_BSR     = 3'd3;
    localparam logic [2:0] GPIO_BRR     = 3'd4;
    localparam logic [2:0] GPIO_RISE_EN = 3'd5;
    localparam logic [2:0] GPIO_FALL_EN = 3'd6;
    localparam logic [2:0] GPIO_ISR     = 3'd7;
endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: multi-stage flop chain bringing asynchronous pin levels into the clk domain
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

    // shift the pin sample one stage deeper every cycle; stage 0 takes the raw pin
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
    end

    // chain registers, cleared on reset so no stale pin state survives it
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign dout = sync_q[STAGES-1];
endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO with direction, atomic set/clear and edge interrupts
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             wr,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             irq,
    inout  wire  [WIDTH-1:0] ioPort
);
    localparam int CW = $clog2(SYNC_STAGES + 2);

    logic [WIDTH-1:0] moder_q, moder_d, odr_q, odr_d, rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d, isr_q, isr_d, idr_q, idr_d;
    logic [WIDTH-1:0] sync_s, wd, edge_set, rd;
    logic [CW-1:0]    settle_q, settle_d;
    logic [2:0]       sel;
    logic             we;
    logic             unused_bits;

    assign unused_bits = ^{addr[31:5], addr[1:0], wdata};

    gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ioPort),
        .dout (sync_s)
    );

    // register writes, edge detection and the post-reset settle countdown
    always_comb begin
        we        = cs & wr;
        sel       = addr[4:2];
        wd        = wdata[WIDTH-1:0];
        moder_d   = (we && sel == GPIO_MODER)   ? wd : moder_q;
        rise_en_d = (we && sel == GPIO_RISE_EN) ? wd : rise_en_q;
        fall_en_d = (we && sel == GPIO_FALL_EN) ? wd : fall_en_q;
        odr_d     = (we && sel == GPIO_ODR) ? wd :
                    (we && sel == GPIO_BSR) ? (odr_q | wd) :
                    (we && sel == GPIO_BRR) ? (odr_q & ~wd) : odr_q;
        edge_set  = ~moder_q & ((~idr_q & sync_s & rise_en_q) | (idr_q & ~sync_s & fall_en_q))
                    & {WIDTH{settle_q == '0}};
        isr_d     = (isr_q & ~((we && sel == GPIO_ISR) ? wd : '0)) | edge_set;
        idr_d     = sync_s;
        settle_d  = (settle_q == '0) ? settle_q : settle_q - 1'b1;
    end

    // state registers; the settle counter blocks ISR until the synchroniser has refilled
    always_ff @(posedge clk) begin
        if (rst) begin
            moder_q   <= '0;
            odr_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            isr_q     <= '0;
            idr_q     <= '0;
            settle_q  <= CW'(SYNC_STAGES + 1);
        end else begin
            moder_q   <= moder_d;
            odr_q     <= odr_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            isr_q     <= isr_d;
            idr_q     <= idr_d;
            settle_q  <= settle_d;
        end
    end

    // combinational read mux; write-only and unmapped bits read as zero
    always_comb begin
        rd = '0;
        case (addr[4:2])
            GPIO_MODER:   rd = moder_q;
            GPIO_IDR:     rd = idr_q;
            GPIO_ODR:     rd = odr_q;
            GPIO_RISE_EN: rd = rise_en_q;
            GPIO_FALL_EN: rd = fall_en_q;
            GPIO_ISR:     rd = isr_q;
            default:      rd = '0;
        endcase
        rdata = 32'(rd);
    end

    assign irq = |isr_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign ioPort[i] = moder_q[i] ? odr_q[i] : 1'bz;
    end
endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised general-purpose I/O controller on the CPU's memory-mapped peripheral bus. It provides per-pin direction control and an output data register with atomic bit set/clear. Inputs pass through a metastability synchroniser, and per-pin rising/falling-edge interrupt detection drives a single level interrupt line toward the core.

## Interface
Parameters:
- WIDTH, 8, number of pins (1..32); register bits above WIDTH-1 read 0 and ignore writes
- SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  reset, synchronous, active-high
- cs  in  1  block select
- wr  in  1  write strobe; a write occurs on a clk edge with cs & wr
- addr  in  32  byte address; only addr[4:2] decoded
- wdata  in  32  write data
- rdata  out  32  read data, combinational from addr[4:2]
- irq  out  1  interrupt, high while any ISR bit is set
- ioPort  inout  WIDTH  pins; bit i driven with ODR[i] when MODER[i]=1, else high-Z

## Operation
Register map (addr[4:2]):
- 0 MODER RW: 1 = output, 0 = input
- 1 IDR RO: synchronised pin state, all bits, including readback of driven outputs
- 2 ODR RW
- 3 BSR WO: 1-bits set ODR bits; reads 0
- 4 BRR WO: 1-bits clear ODR bits; reads 0
- 5 RISE_EN RW: per-pin rising-edge interrupt enable
- 6 FALL_EN RW: per-pin falling-edge interrupt enable
- 7 ISR R/W1C: pending edge flags; writing 1 clears, writing 0 has no effect

Input and interrupt path:
- Input path: ioPort -> SYNC_STAGES flops -> IDR register.
- Edge detect compares the synchroniser output (next IDR) with the current IDR.
  - rise = ~IDR & s; fall = IDR & ~s.
- ISR[i] is set on the edge that updates IDR when `~MODER[i] & ((rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]))`.
- Output-mode pins never set ISR.
- irq = |ISR[WIDTH-1:0]. Clearing an enable does not clear an already-pending ISR bit.

Boundary rules:
- Hardware set and W1C of the same ISR bit in the same cycle: set wins, and the bit stays 1.
- Writes to 0 (MODER) and 2 (ODR) are plain loads.
- BSR and BRR are separate addresses, so no intra-write conflict exists.
- Writes to address 1 (IDR) are ignored.
- Reads have no side effects; a read of ISR does not clear it.
- Switching MODER[i] from 1 to 0 generates no interrupt by itself; it only generates one if the synchronised pin value then differs from IDR and the relevant enable is set.

## Timing
- Reset (synchronous, rst high at a clk edge):
  - MODER, ODR, RISE_EN, FALL_EN, ISR, IDR and all synchroniser flops go to 0.
  - irq = 0; all pins high-Z.
  - rdata reflects the reset registers combinationally.
- Register writes take effect on the clk edge where cs & wr is sampled. The new value is visible on rdata and ioPort immediately after that edge.
- Input latency: a pin change stable before edge k appears in IDR after edge k+SYNC_STAGES.
  - The corresponding ISR bit and irq rise after the same edge.
  - With the default, that is 3 edges after the pin changes.
- Pulses shorter than one clk period may be missed; there is no glitch capture.
- rst asserted mid-operation discards pending interrupts and in-flight synchroniser state. After rst is released, a pin that is already high does not raise a rising-edge interrupt, because IDR resets to 0, the synchroniser fills, and ISR is blocked for SYNC_STAGES+1 cycles after reset.
  - This needs a small post-reset settle counter; ISR set is suppressed while the counter is non-zero.

## Structure
- Shared package gpio_pkg holds:
  - register offset localparams (GPIO_MODER=0 ... GPIO_ISR=7)
  - default WIDTH and SYNC_STAGES
- One sub-module, gpio_sync: a WIDTH-bit, SYNC_STAGES-deep flop chain with synchronous reset, one instance.
- Top level contains:
  - the register file
  - the edge detect, ISR and settle counter
  - the read mux
  - the per-bit tri-state assigns

## Test plan
- Reset, then read all 8 addresses -> all 0; irq=0; ioPort all Z.
- Write MODER=0x0F, ODR=0xA5 -> ioPort[3:0]=0x5, upper pins Z. Write BSR=0x02, then BRR=0x01 -> ODR reads 0xA6, ioPort[3:0]=0x6.
- Set RISE_EN=0x10 and drive ioPort[4] 0->1 -> IDR[4]=1 and ISR=0x10 exactly 3 edges later; irq=1. W1C ISR=0x10 -> irq=0 next cycle.
- Set FALL_EN=0x80 and drive ioPort[7] 1->0 on the same cycle that writes ISR=0x80 (W1C) at the detect edge -> ISR[7] stays 1.
- Set MODER[4]=1 with RISE_EN[4]=1 and toggle ODR[4] -> IDR[4] follows, ISR stays 0.
- Hold ioPort[2]=1 with RISE_EN=0x04, pulse rst for 1 cycle -> ISR stays 0 for all cycles after reset and IDR[2]=1 after 3 edges. A subsequent 1->0->1 on ioPort[2] sets ISR[2].
